// File: rtl/checkbits_monitor.sv
// Checkbits bus monitor: synchronizes and debounces the pad bus, captures values between
// START_MARK and END_MARK into a FWFT FIFO, reports done/pass/timeout. Optional cksum: CHECKBITS_MON_CKSUM_EN.
module checkbits_monitor #(
    parameter int unsigned      WIDTH      = 16,
    parameter logic [WIDTH-1:0] START_MARK = 16'hAB40,
    parameter logic [WIDTH-1:0] END_MARK   = 16'hAB51,
    parameter int unsigned      EXPECT_CNT = 11,
    parameter int unsigned      DEPTH      = 16,
    parameter int unsigned      STABLE_CYC = 2,
    parameter int unsigned      TIMEOUT    = 250000
) (
    input  logic                   clock,
    input  logic                   resetb,
    input  logic [WIDTH-1:0]       checkbits,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic [1:0]             state,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic                   overflow
`ifdef CHECKBITS_MON_CKSUM_EN
    ,
    output logic [31:0]            cksum
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int RW = $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2,
        S_FAIL    = 2'd3
    } state_e;

    logic [WIDTH-1:0] sync1_q, sync2_q, cand_q, cand_d, last_acc_q, acc_val_q;
    logic [RW-1:0]    run_q, run_d;
    logic             reach_s, acc_d, acc_q;
    state_e           state_q;
    logic [PW-1:0]    count_q, wr_ptr_q, rd_ptr_q;
    logic [TW-1:0]    timer_q, timer_nx_s;
    logic             done_q, pass_q, timeout_q, overflow_q;
    logic             empty_s, full_s, start_s, end_s, push_s, pop_s, wr_s, timer_hit_s;
    logic [WIDTH-1:0] mem_q [DEPTH];
`ifdef CHECKBITS_MON_CKSUM_EN
    logic [31:0]      cksum_q;
`endif

    // Stability filter: a run restarts at 1 on change and saturates at STABLE_CYC.
    always_comb begin
        cand_d  = cand_q;
        run_d   = run_q;
        reach_s = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d  = sync2_q;
            run_d   = RW'(1'b1);
            reach_s = (STABLE_CYC == 32'd1);
        end else if (run_q < RW'(STABLE_CYC)) begin
            run_d   = run_q + RW'(1'b1);
            reach_s = (run_d == RW'(STABLE_CYC));
        end else begin
            run_d   = run_q;
        end
        acc_d = reach_s && (cand_d != last_acc_q);
    end

    // Synchronizer, filter state and the registered accept strobe.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1_q    <= {WIDTH{1'b0}};
            sync2_q    <= {WIDTH{1'b0}};
            cand_q     <= {WIDTH{1'b0}};
            run_q      <= {RW{1'b0}};
            last_acc_q <= {WIDTH{1'b0}};
            acc_q      <= 1'b0;
            acc_val_q  <= {WIDTH{1'b0}};
        end else begin
            sync1_q   <= checkbits;
            sync2_q   <= sync1_q;
            cand_q    <= cand_d;
            run_q     <= run_d;
            acc_q     <= acc_d;
            acc_val_q <= cand_d;
            if (acc_d) last_acc_q <= cand_d;
            else       last_acc_q <= last_acc_q;
        end
    end

    assign empty_s     = (wr_ptr_q == rd_ptr_q);
    assign full_s      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign start_s     = acc_q && (acc_val_q == START_MARK);
    assign end_s       = acc_q && (acc_val_q == END_MARK);
    assign push_s      = (state_q == S_CAPTURE) && acc_q && !end_s;
    assign pop_s       = rd_en && !empty_s;
    assign wr_s        = push_s && (!full_s || pop_s);
    assign timer_nx_s  = timer_q + TW'(1'b1);
    assign timer_hit_s = (timer_nx_s == TW'(TIMEOUT));

    // Window FSM with timer, count and sticky verdicts; END_MARK beats a same-cycle timeout.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q    <= S_IDLE;
            timer_q    <= {TW{1'b0}};
            count_q    <= {PW{1'b0}};
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
`ifdef CHECKBITS_MON_CKSUM_EN
            cksum_q    <= 32'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_CAPTURE: begin
                    timer_q <= timer_nx_s;
                    if ((state_q == S_CAPTURE) && end_s) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        pass_q  <= (count_q == PW'(EXPECT_CNT)) && !overflow_q;
                    end else if (timer_hit_s) begin
                        state_q   <= S_FAIL;
                        timeout_q <= 1'b1;
                        pass_q    <= 1'b0;
                    end else if ((state_q == S_IDLE) && start_s) begin
                        state_q <= S_CAPTURE;
                        count_q <= {PW{1'b0}};
`ifdef CHECKBITS_MON_CKSUM_EN
                        cksum_q <= 32'd0;
`endif
                    end else begin
                        state_q <= state_q;
                    end
                    if (push_s) begin
                        if (count_q != {PW{1'b1}}) count_q <= count_q + PW'(1'b1);
                        if (!wr_s) overflow_q <= 1'b1;
`ifdef CHECKBITS_MON_CKSUM_EN
                        cksum_q <= cksum_q + 32'(acc_val_q);
`endif
                    end
                end
                S_DONE, S_FAIL: state_q <= state_q;
                default:        state_q <= S_FAIL;
            endcase
        end
    end

    // FIFO pointers; push and pop may both happen in one cycle.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
        end else begin
            if (wr_s)  wr_ptr_q <= wr_ptr_q + PW'(1'b1);
            else       wr_ptr_q <= wr_ptr_q;
            if (pop_s) rd_ptr_q <= rd_ptr_q + PW'(1'b1);
            else       rd_ptr_q <= rd_ptr_q;
        end
    end

    // Storage array; unreset because rd_data is masked while empty.
    always_ff @(posedge clock) begin
        if (wr_s) mem_q[wr_ptr_q[AW-1:0]] <= acc_val_q;
    end

    assign rd_valid = !empty_s;
    assign rd_data  = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];
    assign count    = count_q;
    assign state    = state_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign timeout  = timeout_q;
    assign overflow = overflow_q;
`ifdef CHECKBITS_MON_CKSUM_EN
    assign cksum    = cksum_q;
`endif

endmodule

// File: tb/tb_checkbits_monitor.sv
// Bench for checkbits_monitor: a pad-sample-history reference model compared every cycle,
// plus directed scenarios with hand-computed expectations and a short-timeout instance.
`timescale 1ns/1ps
module tb_checkbits_monitor;
    localparam int          SC      = 2;
    localparam int          DEPTH   = 16;
    localparam int          EXPECTN = 11;
    localparam int          MAIN_TO = 250000;
    localparam logic [15:0] STARTM  = 16'hAB40;
    localparam logic [15:0] ENDM    = 16'hAB51;

    logic        clock = 1'b0;
    logic        resetb = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] checkbits = 16'h0000;

    logic [15:0] rd_data, to_rd_data;
    logic        rd_valid, to_rd_valid;
    logic [4:0]  count, to_count;
    logic [1:0]  state, to_state;
    logic        done, pass, timeout, overflow;
    logic        to_done, to_pass, to_timeout, to_overflow;
`ifdef CHECKBITS_MON_CKSUM_EN
    logic [31:0] cksum, to_cksum;
`endif

    always #5 clock = ~clock;

    checkbits_monitor dut (
        .clock(clock), .resetb(resetb), .checkbits(checkbits), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .state(state),
        .done(done), .pass(pass), .timeout(timeout), .overflow(overflow)
`ifdef CHECKBITS_MON_CKSUM_EN
        , .cksum(cksum)
`endif
    );

    checkbits_monitor #(.TIMEOUT(100)) u_to (
        .clock(clock), .resetb(resetb), .checkbits(checkbits), .rd_en(rd_en),
        .rd_data(to_rd_data), .rd_valid(to_rd_valid), .count(to_count), .state(to_state),
        .done(to_done), .pass(to_pass), .timeout(to_timeout), .overflow(to_overflow)
`ifdef CHECKBITS_MON_CKSUM_EN
        , .cksum(to_cksum)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pad samples since reset, accepted values, queue and flags.
    logic [15:0] m_hist [0:SC+3];
    logic [15:0] m_last;
    logic [15:0] m_q [$];
    int          m_state, m_count, m_timer;
    bit          m_done, m_pass, m_to, m_ovf;
    logic [31:0] m_cksum;

    task m_clear();
        for (int k = 0; k <= SC + 3; k++) m_hist[k] = 16'h0000;
        m_last = 16'h0000; m_q.delete();
        m_state = 0; m_count = 0; m_timer = 0;
        m_done = 0; m_pass = 0; m_to = 0; m_ovf = 0; m_cksum = 32'd0;
    endtask

    task m_step();
        bit ev, full, pop, push, fin, strt;
        logic [15:0] v;
        for (int k = SC + 3; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = checkbits;
        // A value counts once it has been sampled exactly SC times in a row, seen 3 edges later.
        v  = m_hist[3];
        ev = (m_hist[SC+3] != v);
        for (int k = 3; k <= SC + 2; k++) if (m_hist[k] != v) ev = 0;
        if (ev && v == m_last) ev = 0;
        if (ev) m_last = v;
        full = (m_q.size() == DEPTH);
        pop  = rd_en && (m_q.size() > 0);
        push = 0;
        if (m_state <= 1) begin
            m_timer++;
            fin  = (m_state == 1) && ev && (v == ENDM);
            push = (m_state == 1) && ev && (v != ENDM);
            strt = (m_state == 0) && ev && (v == STARTM);
            if (fin) begin
                m_state = 2; m_done = 1; m_pass = (m_count == EXPECTN) && !m_ovf;
            end else if (m_timer == MAIN_TO) begin
                m_state = 3; m_to = 1; m_pass = 0;
            end else if (strt) begin
                m_state = 1; m_count = 0; m_cksum = 32'd0;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_count < 31) m_count++;
            m_cksum = m_cksum + {16'h0000, v};
            if (full && !pop) m_ovf = 1;
            else m_q.push_back(v);
        end
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clock or negedge resetb);
            if (!resetb) m_clear();
            else m_step();
        end
    end

    // Per-cycle comparison of the main instance against the model.
    initial begin
        forever begin
            @(negedge clock);
            chk("m_state", {30'd0, state}, m_state);
            chk("m_count", {27'd0, count}, m_count);
            chk("m_done", {31'd0, done}, {31'd0, m_done});
            chk("m_pass", {31'd0, pass}, {31'd0, m_pass});
            chk("m_timeout", {31'd0, timeout}, {31'd0, m_to});
            chk("m_overflow", {31'd0, overflow}, {31'd0, m_ovf});
            chk("m_rd_valid", {31'd0, rd_valid}, {31'd0, (m_q.size() > 0)});
            if (m_q.size() > 0) chk("m_rd_data", {16'd0, rd_data}, {16'd0, m_q[0]});
`ifdef CHECKBITS_MON_CKSUM_EN
            chk("m_cksum", cksum, m_cksum);
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic hold(input logic [15:0] v, input int n);
        checkbits = v;
        tick(n);
    endtask

    task automatic do_reset(input logic [15:0] pad);
        resetb = 1'b0; rd_en = 1'b0; checkbits = pad;
        tick(3);
        resetb = 1'b1;
    endtask

    task automatic pop_expect(input string name, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk(name, {16'd0, rd_data}, first + i);
            rd_en = 1'b1;
            tick(1);
        end
        rd_en = 1'b0;
        @(negedge clock);
        chk({name, "_empty"}, {31'd0, rd_valid}, 32'd0);
    endtask

    initial begin
        // Reset held with START_MARK on the pad, then release latency.
        resetb = 1'b0; checkbits = STARTM; rd_en = 1'b0;
        tick(3);
        @(negedge clock);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
        chk("rst_flags", {28'd0, done, pass, timeout, overflow}, 32'd0);
        resetb = 1'b1;
        tick(4);
        @(negedge clock);
        chk("start_lat_m1", {30'd0, state}, 32'd0);
        tick(1);
        @(negedge clock);
        chk("start_lat", {30'd0, state}, 32'd1);

        // Normal run: 1..11 then END_MARK.
        tick(5);
        for (int i = 1; i <= 11; i++) hold(16'(i), 10);
        hold(ENDM, 10);
        @(negedge clock);
        chk("norm_count", {27'd0, count}, 32'd11);
        chk("norm_done", {31'd0, done}, 32'd1);
        chk("norm_pass", {31'd0, pass}, 32'd1);
        chk("norm_state", {30'd0, state}, 32'd2);
`ifdef CHECKBITS_MON_CKSUM_EN
        chk("norm_cksum", cksum, 32'd66);
`endif
        pop_expect("norm_pop", 1, 11);

        // One-clock glitch inside the window is filtered out.
        do_reset(STARTM);
        tick(10);
        hold(16'd1, 10);
        hold(16'd2, 10);
        hold(16'd5, 1);
        hold(16'd2, 10);
        @(negedge clock);
        chk("glitch_count", {27'd0, count}, 32'd2);
        chk("glitch_state", {30'd0, state}, 32'd1);
        hold(ENDM, 10);
        @(negedge clock);
        chk("glitch_done", {31'd0, done}, 32'd1);
        chk("glitch_pass", {31'd0, pass}, 32'd0);

        // Overflow: 20 values, no reads.
        do_reset(STARTM);
        tick(10);
        for (int i = 1; i <= 20; i++) hold(16'(i), 6);
        hold(ENDM, 10);
        @(negedge clock);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_count", {27'd0, count}, 32'd20);
        chk("ovf_rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("ovf_pass", {31'd0, pass}, 32'd0);
`ifdef CHECKBITS_MON_CKSUM_EN
        chk("ovf_cksum", cksum, 32'd210);
`endif
        pop_expect("ovf_pop", 1, 16);

        // Timeout instance: pad idle, expires exactly 100 clocks after release.
        do_reset(16'h0000);
        tick(99);
        @(negedge clock);
        chk("to_state_99", {30'd0, to_state}, 32'd0);
        chk("to_flag_99", {31'd0, to_timeout}, 32'd0);
        tick(1);
        @(negedge clock);
        chk("to_state_100", {30'd0, to_state}, 32'd3);
        chk("to_flag_100", {31'd0, to_timeout}, 32'd1);
        chk("to_pass", {31'd0, to_pass}, 32'd0);
        chk("to_fifo", {to_rd_data, 10'd0, to_count, to_rd_valid, to_overflow}, 32'd0);
`ifdef CHECKBITS_MON_CKSUM_EN
        chk("to_cksum", to_cksum, 32'd0);
`endif

        // END_MARK accepted on the same clock the timer expires.
        do_reset(STARTM);
        tick(95);
        checkbits = ENDM;
        tick(4);
        @(negedge clock);
        chk("tie_state_99", {30'd0, to_state}, 32'd1);
        tick(1);
        @(negedge clock);
        chk("tie_state", {30'd0, to_state}, 32'd2);
        chk("tie_timeout", {31'd0, to_timeout}, 32'd0);
        chk("tie_done", {31'd0, to_done}, 32'd1);

        // Reset mid-capture, then a fresh passing run.
        do_reset(STARTM);
        tick(10);
        for (int i = 1; i <= 5; i++) hold(16'(i), 8);
        @(negedge clock);
        chk("mid_count5", {27'd0, count}, 32'd5);
        tick(1);
        resetb = 1'b0;
        @(negedge clock);
        chk("mid_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("mid_count", {27'd0, count}, 32'd0);
        chk("mid_state", {30'd0, state}, 32'd0);
        checkbits = STARTM;
        tick(2);
        resetb = 1'b1;
        tick(10);
        for (int i = 1; i <= 11; i++) hold(16'(i), 10);
        hold(ENDM, 10);
        @(negedge clock);
        chk("rerun_pass", {31'd0, pass}, 32'd1);
        chk("rerun_count", {27'd0, count}, 32'd11);
        pop_expect("rerun_pop", 1, 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
